// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer.
// Holds the opcode constants, the T-state bit positions of the one-hot ring and the
// control-word struct that the decoder builds each cycle.
package sap1_pkg;

  localparam int unsigned NumTStates = 6;

  // Bit positions inside the one-hot t_state vector.
  localparam int unsigned T1Idx = 0;
  localparam int unsigned T2Idx = 1;
  localparam int unsigned T3Idx = 2;
  localparam int unsigned T4Idx = 3;
  localparam int unsigned T5Idx = 4;
  localparam int unsigned T6Idx = 5;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OpLda = 4'b0000;
  localparam opcode_t OpAdd = 4'b0001;
  localparam opcode_t OpSub = 4'b0010;
  localparam opcode_t OpOut = 4'b1110;
  localparam opcode_t OpHlt = 4'b1111;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic mar_load;
    logic ram_out;
    logic instr_load;
    logic instr_send;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_sub;
    logic alu_out;
    logic out_load;
  } ctrl_word_t;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter (T1..T6).
// Ports:
//   clk   - system clock, advances on posedge
//   rst   - asynchronous active-high reset, forces T1
//   hold  - when high the ring keeps its current state
//   ring  - one-hot state, bit0 = T1 .. bit5 = T6
module ring_counter
  import sap1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  output logic [NumTStates-1:0] ring
);

  logic [NumTStates-1:0] ring_q;
  logic [NumTStates-1:0] ring_d;

  always_comb begin
    ring_d = ring_q;
    if (!hold) begin
      // Rotate left: T6 wraps straight back to T1.
      ring_d = {ring_q[NumTStates-2:0], ring_q[NumTStates-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q <= NumTStates'(1);
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring = ring_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: one-hot T-state ring plus combinational control-word decode
// and a sticky halt flag.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   opcode   - instruction opcode from the instruction register
//   t_state  - one-hot ring state, bit0 = T1 .. bit5 = T6
//   pc_out .. out_load - active-high control lines
//   halt     - sticky halt flag for the clock gate
module control_sequencer
  import sap1_pkg::*;
#(
  parameter int DEBUG = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       instr_load,
  output logic       instr_send,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic       halt
);

  logic       halt_q;
  logic       halt_d;
  logic       hlt_at_t4;
  ctrl_word_t ctrl;

  // HLT seen in T4 freezes the ring on the same edge that sets the flag, so it parks at T4.
  assign hlt_at_t4 = t_state[T4Idx] && (opcode == OpHlt);

  always_comb begin
    halt_d = halt_q | hlt_at_t4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  ring_counter u_ring (
    .clk  (clk),
    .rst  (rst),
    .hold (halt_d),
    .ring (t_state)
  );

  always_comb begin
    ctrl = '0;
    // rst gates the decode so no control line is asserted while reset is held.
    if (!rst && !halt_q) begin
      unique case (1'b1)
        t_state[T1Idx]: begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        t_state[T2Idx]: begin
          ctrl.pc_inc = 1'b1;
        end
        t_state[T3Idx]: begin
          ctrl.ram_out    = 1'b1;
          ctrl.instr_load = 1'b1;
        end
        t_state[T4Idx]: begin
          case (opcode)
            OpLda, OpAdd, OpSub: begin
              ctrl.instr_send = 1'b1;
              ctrl.mar_load   = 1'b1;
            end
            OpOut: begin
              ctrl.a_out    = 1'b1;
              ctrl.out_load = 1'b1;
            end
            default: ;
          endcase
        end
        t_state[T5Idx]: begin
          case (opcode)
            OpLda: begin
              ctrl.ram_out = 1'b1;
              ctrl.a_load  = 1'b1;
            end
            OpAdd: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_load  = 1'b1;
            end
            OpSub: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_load  = 1'b1;
              ctrl.alu_sub = 1'b1;
            end
            default: ;
          endcase
        end
        t_state[T6Idx]: begin
          case (opcode)
            OpAdd: begin
              ctrl.alu_out = 1'b1;
              ctrl.a_load  = 1'b1;
            end
            OpSub: begin
              ctrl.alu_out = 1'b1;
              ctrl.a_load  = 1'b1;
              ctrl.alu_sub = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // The per-clock trace selected by DEBUG is printed by the simulation harness from the
  // ports; this block only anchors the parameter in the design hierarchy.
  if (DEBUG != 0) begin : g_debug
  end

  assign pc_out     = ctrl.pc_out;
  assign pc_inc     = ctrl.pc_inc;
  assign mar_load   = ctrl.mar_load;
  assign ram_out    = ctrl.ram_out;
  assign instr_load = ctrl.instr_load;
  assign instr_send = ctrl.instr_send;
  assign a_load     = ctrl.a_load;
  assign a_out      = ctrl.a_out;
  assign b_load     = ctrl.b_load;
  assign alu_sub    = ctrl.alu_sub;
  assign alu_out    = ctrl.alu_out;
  assign out_load   = ctrl.out_load;
  assign halt       = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int DEBUG = 0;

  // Control word bit order: {pc_out, pc_inc, mar_load, ram_out, instr_load, instr_send,
  //                          a_load, a_out, b_load, alu_sub, alu_out, out_load}
  localparam logic [11:0] CPcOut     = 12'h800;
  localparam logic [11:0] CPcInc     = 12'h400;
  localparam logic [11:0] CMarLoad   = 12'h200;
  localparam logic [11:0] CRamOut    = 12'h100;
  localparam logic [11:0] CInstrLoad = 12'h080;
  localparam logic [11:0] CInstrSend = 12'h040;
  localparam logic [11:0] CALoad     = 12'h020;
  localparam logic [11:0] CAOut      = 12'h010;
  localparam logic [11:0] CBLoad     = 12'h008;
  localparam logic [11:0] CAluSub    = 12'h004;
  localparam logic [11:0] CAluOut    = 12'h002;
  localparam logic [11:0] COutLoad   = 12'h001;
  localparam logic [11:0] CNone      = 12'h000;

  localparam logic [11:0] F1 = CPcOut | CMarLoad;
  localparam logic [11:0] F2 = CPcInc;
  localparam logic [11:0] F3 = CRamOut | CInstrLoad;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  ts;
    logic [11:0] ctl;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [5:0]  t_state;
  logic        pc_out, pc_inc, mar_load, ram_out, instr_load, instr_send;
  logic        a_load, a_out, b_load, alu_sub, alu_out, out_load;
  logic        halt;
  logic [11:0] ctrl_act;
  logic [4:0]  bus_drv;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  control_sequencer #(.DEBUG(DEBUG)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .t_state    (t_state),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .mar_load   (mar_load),
    .ram_out    (ram_out),
    .instr_load (instr_load),
    .instr_send (instr_send),
    .a_load     (a_load),
    .a_out      (a_out),
    .b_load     (b_load),
    .alu_sub    (alu_sub),
    .alu_out    (alu_out),
    .out_load   (out_load),
    .halt       (halt)
  );

  assign ctrl_act = {pc_out, pc_inc, mar_load, ram_out, instr_load, instr_send,
                     a_load, a_out, b_load, alu_sub, alu_out, out_load};
  assign bus_drv  = {pc_out, ram_out, instr_send, a_out, alu_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-contention and one-hot monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (DEBUG != 0) begin
      $display("t=%0t t_state=%b opcode=%b ctrl=%h halt=%b", $time, t_state, opcode,
               ctrl_act, halt);
    end
    if (!rst) begin
      total++;
      assert (($countones(bus_drv) <= 1) && $onehot(t_state)) else begin
        bad++;
        $display("FAIL bus_onehot: got bus=%b t_state=%b, want at most one driver, one-hot",
                 bus_drv, t_state);
      end
    end
  end

  task automatic check(input string name, input logic [5:0] ets, input logic [11:0] ectl,
                       input logic eh);
    total++;
    if (t_state !== ets || ctrl_act !== ectl || halt !== eh) begin
      bad++;
      $display("FAIL %s: got t_state=%b ctrl=%h halt=%b, want t_state=%b ctrl=%h halt=%b",
               name, t_state, ctrl_act, halt, ets, ectl, eh);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [5:0] ts, input logic [11:0] ctl);
    vec_t v;
    v.op  = op;
    v.ts  = ts;
    v.ctl = ctl;
    vecs.push_back(v);
  endtask

  initial begin
    // LDA, ADD, SUB
    add(4'h0, T1, F1); add(4'h0, T2, F2); add(4'h0, T3, F3);
    add(4'h0, T4, CInstrSend | CMarLoad); add(4'h0, T5, CRamOut | CALoad); add(4'h0, T6, CNone);
    add(4'h1, T1, F1); add(4'h1, T2, F2); add(4'h1, T3, F3);
    add(4'h1, T4, CInstrSend | CMarLoad); add(4'h1, T5, CRamOut | CBLoad);
    add(4'h1, T6, CAluOut | CALoad);
    add(4'h2, T1, F1); add(4'h2, T2, F2); add(4'h2, T3, F3);
    add(4'h2, T4, CInstrSend | CMarLoad); add(4'h2, T5, CRamOut | CBLoad | CAluSub);
    add(4'h2, T6, CAluOut | CALoad | CAluSub);
    // OUT
    add(4'hE, T1, F1); add(4'hE, T2, F2); add(4'hE, T3, F3);
    add(4'hE, T4, CAOut | COutLoad); add(4'hE, T5, CNone); add(4'hE, T6, CNone);
    // Opcode wobbling during fetch (including HLT) must not matter; then illegal 0101.
    add(4'hF, T1, F1); add(4'h3, T2, F2); add(4'hF, T3, F3);
    add(4'h5, T4, CNone); add(4'h5, T5, CNone); add(4'h5, T6, CNone);
    // Wrap T6 -> T1
    add(4'h0, T1, F1);

    rst    = 1'b0;
    opcode = 4'h0;
    #1 rst = 1'b1;
    #1 check("reset_initial", T1, CNone, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      #1 check($sformatf("vec%0d", i), vecs[i].ts, vecs[i].ctl, 1'b0);
      @(negedge clk);
    end

    // Reset asserted mid-T5 of an LDA; state now T2.
    opcode = 4'h0;
    repeat (3) @(negedge clk);
    #1 check("pre_reset_t5", T5, CRamOut | CALoad, 1'b0);
    #2 rst = 1'b1;
    #1 check("reset_mid_t5", T1, CNone, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset_t1", T1, F1, 1'b0);
    @(negedge clk);
    #1 check("post_reset_t2", T2, F2, 1'b0);

    // HLT: freeze at T4, controls off, survives opcode changes, cleared by reset.
    opcode = 4'hF;
    @(negedge clk);
    #1 check("hlt_t3", T3, F3, 1'b0);
    @(negedge clk);
    #1 check("hlt_t4", T4, CNone, 1'b0);
    @(negedge clk);
    #1 check("hlt_set", T4, CNone, 1'b1);
    for (int k = 0; k < 10; k++) begin
      opcode = 4'(k);
      @(negedge clk);
      #1 check($sformatf("halted%0d", k), T4, CNone, 1'b1);
    end
    #2 rst = 1'b1;
    #1 check("halt_reset", T1, CNone, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    opcode = 4'h0;
    #1 check("halt_release_t1", T1, F1, 1'b0);
    @(negedge clk);
    #1 check("halt_release_t2", T2, F2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter: DEBUG, 0, when 1 print T-state, opcode and control word each clock.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: opcode  input  4  current instruction opcode from instruction register.
REQ-005 SHALL have port: t_state  output  6  one-hot ring state, bit0=T1 .. bit5=T6.
REQ-006 SHALL have ports, each output 1, active-high: pc_out, pc_inc, mar_load, ram_out, instr_load, instr_send, a_load, a_out, b_load, alu_sub, alu_out, out_load.
REQ-007 SHALL have port: halt  output  1  sticky halt flag to the clock gate.

Function
REQ-008 SHALL hold a six-state one-hot ring counter T1->T2->T3->T4->T5->T6->T1, advancing one state per posedge clk.
REQ-009 SHALL wrap T6 to T1 with no idle cycle; exactly one t_state bit SHALL be high at all times outside reset.
REQ-010 SHALL decode control outputs combinationally from registered t_state and opcode; zero added latency.
REQ-011 Fetch, opcode-independent: T1 pc_out+mar_load; T2 pc_inc; T3 ram_out+instr_load.
REQ-012 LDA (0000): T4 instr_send+mar_load; T5 ram_out+a_load; T6 none.
REQ-013 ADD (0001): T4 instr_send+mar_load; T5 ram_out+b_load; T6 alu_out+a_load.
REQ-014 SUB (0010): same as ADD, plus alu_sub high in T5 and T6.
REQ-015 OUT (1110): T4 a_out+out_load; T5, T6 none.
REQ-016 HLT (1111): on the posedge leaving T4, halt SHALL set to 1 and the ring SHALL freeze at T4.
REQ-017 While halt=1 all control outputs SHALL be 0; halt SHALL clear only on reset.
REQ-018 Undefined opcodes (0011-1101) SHALL be no-ops: T4-T6 all controls 0, ring continues.
REQ-019 Opcode changes during T1-T3 SHALL NOT affect outputs in those states.
REQ-020 No two bus drivers (pc_out, ram_out, instr_send, a_out, alu_out) SHALL be high in the same state.

Reset
REQ-021 rst high SHALL immediately force t_state=000001 (T1), halt=0, and all control outputs 0, independent of clk.
REQ-022 Reset asserted mid-instruction (any T-state, including halted) SHALL abandon the instruction; no partial load completes after rst rises.
REQ-023 After rst falls, the T1 control word SHALL appear combinationally; the first posedge SHALL advance to T2.

Structure
REQ-024 Opcode constants (LDA, ADD, SUB, OUT, HLT) and T-state bit indices SHALL live in a shared package sap1_pkg.
REQ-025 The ring counter SHALL be one sub-module, ring_counter, with clk, rst, hold, and a 6-bit one-hot output.
REQ-026 Control-word decode and halt flag SHALL live in control_sequencer.

Verification
REQ-027 Reset: rst=1 asynchronously mid-T5 -> t_state=000001, halt=0, all controls 0 before next clk.
REQ-028 Fetch: rst released, 3 clocks -> T1 {pc_out,mar_load}, T2 {pc_inc}, T3 {ram_out,instr_load}.
REQ-029 LDA/ADD/SUB: opcode=0000, 0001, 0010 in successive instructions -> T4-T6 control words per REQ-012..014, alu_sub only for 0010 in T5/T6.
REQ-030 OUT then wrap: opcode=1110 -> T4 {a_out,out_load}; after T6 the next clock yields T1.
REQ-031 HLT: opcode=1111 -> halt=1 after T4 edge; 10 further clocks keep t_state=001000, controls 0; rst pulse clears halt.
REQ-032 Illegal/contention: opcode=0101 -> T4-T6 all controls 0; every cycle, at most one bus driver high (assertion).
